// File: rtl/demux14_buf.sv
// demux14_buf: buffered 1-to-4 demultiplexer.
// A single producer offers a DATA_W word plus a 2-bit destination index.
// Each destination owns a DEPTH-entry FIFO, so a stalled consumer only
// blocks traffic addressed to it.
//
// Ports:
//   clk, rst_n                 rising-edge clock, async active-low reset
//   sel, din, din_valid        producer side (destination, word, offer)
//   din_ready                  word accepted this cycle (destination not full)
//   dout_k, dout_valid_k       head of FIFO k (zero when empty), FIFO k non-empty
//   dout_ready_k               consumer k takes the head this cycle
module demux14_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [DATA_W-1:0] dout_0,
    output logic [DATA_W-1:0] dout_1,
    output logic [DATA_W-1:0] dout_2,
    output logic [DATA_W-1:0] dout_3,
    output logic              dout_valid_0,
    output logic              dout_valid_1,
    output logic              dout_valid_2,
    output logic              dout_valid_3,
    input  logic              dout_ready_0,
    input  logic              dout_ready_1,
    input  logic              dout_ready_2,
    input  logic              dout_ready_3
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [3:0]        rdy;
    logic [3:0]        vld;
    logic [CNT_W-1:0]  cnt  [4];
    logic [DATA_W-1:0] head [4];

    assign rdy = {dout_ready_3, dout_ready_2, dout_ready_1, dout_ready_0};

    // Only the selected FIFO's registered occupancy gates acceptance; a pop
    // in the same cycle does not free a slot for the incoming word.
    assign din_ready = (cnt[sel] != FULL);

    for (genvar k = 0; k < 4; k++) begin : g_fifo
        logic [DATA_W-1:0] mem [DEPTH];
        logic [PTR_W-1:0]  rd_ptr;
        logic [PTR_W-1:0]  wr_ptr;
        logic [CNT_W-1:0]  count;
        logic              push;
        logic              pop;

        assign push = din_valid && din_ready && (sel == 2'(k));
        assign pop  = (count != '0) && rdy[k];

        // DEPTH is a power of two, so pointer wrap is the natural overflow.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
            end else begin
                if (push) begin
                    mem[wr_ptr] <= din;
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (pop && !push) begin
                    count <= count - CNT_W'(1);
                end
            end
        end

        assign cnt[k]  = count;
        assign vld[k]  = (count != '0);
        assign head[k] = vld[k] ? mem[rd_ptr] : '0;
    end

    assign dout_0       = head[0];
    assign dout_1       = head[1];
    assign dout_2       = head[2];
    assign dout_3       = head[3];
    assign dout_valid_0 = vld[0];
    assign dout_valid_1 = vld[1];
    assign dout_valid_2 = vld[2];
    assign dout_valid_3 = vld[3];

endmodule

// File: tb/tb_demux14_buf.sv
// tb_demux14_buf: self-checking bench for demux14_buf.
// Expected behaviour comes from a queue-per-port model: a word is accepted
// when its destination queue holds fewer than DEPTH entries, and each port
// pops its queue front when the consumer is ready.
module tb_demux14_buf;

    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    sel;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic [DW-1:0] dout_0, dout_1, dout_2, dout_3;
    logic          dout_valid_0, dout_valid_1, dout_valid_2, dout_valid_3;
    logic [3:0]    rdy;

    logic [DW-1:0] dout_a [4];
    logic [3:0]    vld_a;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q      [4][$];
    logic [DW-1:0] popped [4][$];
    logic          exp_ready;
    logic          obs_ready;

    always #5 clk = ~clk;

    demux14_buf #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sel          (sel),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .dout_0       (dout_0),
        .dout_1       (dout_1),
        .dout_2       (dout_2),
        .dout_3       (dout_3),
        .dout_valid_0 (dout_valid_0),
        .dout_valid_1 (dout_valid_1),
        .dout_valid_2 (dout_valid_2),
        .dout_valid_3 (dout_valid_3),
        .dout_ready_0 (rdy[0]),
        .dout_ready_1 (rdy[1]),
        .dout_ready_2 (rdy[2]),
        .dout_ready_3 (rdy[3])
    );

    assign dout_a[0] = dout_0;
    assign dout_a[1] = dout_1;
    assign dout_a[2] = dout_2;
    assign dout_a[3] = dout_3;
    assign vld_a     = {dout_valid_3, dout_valid_2, dout_valid_1, dout_valid_0};

    // One clock: sample pre-edge, then advance the model across the edge.
    // Called shortly after a rising edge with inputs already applied.
    task automatic step();
        logic [DW-1:0] tmp;
        exp_ready = (q[sel].size() != DEPTH);
        #1;
        obs_ready = din_ready;
        for (int k = 0; k < 4; k++) begin
            if (vld_a[k] && rdy[k]) popped[k].push_back(dout_a[k]);
        end
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (q[k].size() != 0 && rdy[k]) tmp = q[k].pop_front();
        end
        if (din_valid && exp_ready) q[sel].push_back(din);
        #1;
    endtask

    task automatic clear_popped();
        for (int k = 0; k < 4; k++) popped[k].delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sel = 2'd0; din = '0; din_valid = 1'b0; rdy = 4'h0;
        #3;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            checks++;
            if (din_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_din_ready sel=%0d got %b want 1", s, din_ready);
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (vld_a[k] !== 1'b0 || dout_a[k] !== '0) begin
                errors++;
                $display("FAIL reset_dout k=%0d got valid=%b data=%h want 0/0", k, vld_a[k], dout_a[k]);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sel = 2'd2;
        #1;
        checks++;
        if (din_ready !== 1'b1 || vld_a !== 4'h0) begin
            errors++;
            $display("FAIL post_reset_idle got ready=%b valid=%b want 1/0000", din_ready, vld_a);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_routing();
        logic [DW-1:0] w [4];
        w[0] = 32'hA000_0000; w[1] = 32'hA100_0001;
        w[2] = 32'hA200_0002; w[3] = 32'hA300_0003;
        clear_popped();
        rdy = 4'h0;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i); din = w[i]; din_valid = 1'b1;
            step();
            checks++;
            if (obs_ready !== 1'b1) begin
                errors++;
                $display("FAIL routing_ready i=%0d got %b want 1", i, obs_ready);
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (vld_a[k] !== (k <= i) || dout_a[k] !== ((k <= i) ? w[k] : '0)) begin
                    errors++;
                    $display("FAIL routing_port i=%0d k=%0d got valid=%b data=%h want %b/%h",
                             i, k, vld_a[k], dout_a[k], (k <= i), ((k <= i) ? w[k] : 32'h0));
                end
            end
        end
        din_valid = 1'b0; rdy = 4'hF;
        step();
        rdy = 4'h0;
        checks++;
        if (vld_a !== 4'h0) begin
            errors++;
            $display("FAIL routing_drain got valid=%b want 0000", vld_a);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (popped[k].size() != 1 || popped[k][0] !== w[k]) begin
                errors++;
                $display("FAIL routing_popped k=%0d got n=%0d want 1 word %h", k, popped[k].size(), w[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_popped();
        rdy = 4'h0;
        for (int i = 0; i < DEPTH; i++) begin
            sel = 2'd2; din = 32'hB200_0000 + DW'(i); din_valid = 1'b1;
            step();
            checks++;
            if (obs_ready !== 1'b1) begin
                errors++;
                $display("FAIL bp_fill_ready i=%0d got %b want 1", i, obs_ready);
            end
        end
        sel = 2'd2; din = 32'hB2FF_FFFF; din_valid = 1'b1;
        step();
        checks++;
        if (obs_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full_ready got %b want 0", obs_ready);
        end
        sel = 2'd1; din = 32'hB100_0000;
        step();
        checks++;
        if (obs_ready !== 1'b1 || vld_a[1] !== 1'b1 || dout_a[1] !== 32'hB100_0000) begin
            errors++;
            $display("FAIL bp_other_port got ready=%b valid=%b data=%h want 1/1/b1000000",
                     obs_ready, vld_a[1], dout_a[1]);
        end
        checks++;
        if (vld_a[2] !== 1'b1 || dout_a[2] !== 32'hB200_0000) begin
            errors++;
            $display("FAIL bp_head2 got valid=%b data=%h want 1/b2000000", vld_a[2], dout_a[2]);
        end
    endtask

    task automatic test_full_pop();
        sel = 2'd2; din = 32'hB200_0010; din_valid = 1'b1; rdy = 4'b0100;
        step();
        checks++;
        if (obs_ready !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_refuse got %b want 0", obs_ready);
        end
        checks++;
        if (dout_a[2] !== 32'hB200_0001) begin
            errors++;
            $display("FAIL fullpop_head got %h want b2000001", dout_a[2]);
        end
        rdy = 4'h0;
        step();
        checks++;
        if (obs_ready !== 1'b1) begin
            errors++;
            $display("FAIL fullpop_retry got %b want 1", obs_ready);
        end
        din_valid = 1'b0;
        #1;
        checks++;
        if (din_ready !== 1'b0 || dout_a[2] !== 32'hB200_0001) begin
            errors++;
            $display("FAIL fullpop_refull got ready=%b head=%h want 0/b2000001", din_ready, dout_a[2]);
        end
        rdy = 4'hF;
        repeat (DEPTH + 1) step();
        rdy = 4'h0;
        checks++;
        if (vld_a !== 4'h0) begin
            errors++;
            $display("FAIL fullpop_drain got valid=%b want 0000", vld_a);
        end
        checks++;
        if (popped[2].size() != DEPTH + 1) begin
            errors++;
            $display("FAIL fullpop_count got %0d want %0d", popped[2].size(), DEPTH + 1);
        end else begin
            for (int i = 0; i <= DEPTH; i++) begin
                checks++;
                if (popped[2][i] !== ((i < DEPTH) ? 32'hB200_0000 + DW'(i) : 32'hB200_0010)) begin
                    errors++;
                    $display("FAIL fullpop_order i=%0d got %h", i, popped[2][i]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int n = 10 * DEPTH;
        int pushed = 0;
        int cyc = 0;
        clear_popped();
        while (popped[0].size() < n && cyc < 2000) begin
            sel = 2'd0;
            din_valid = (pushed < n);
            din = 32'hC000_0000 + DW'(pushed);
            rdy = {3'b000, 1'($urandom_range(0, 1))};
            step();
            if (obs_ready !== exp_ready) begin
                errors++;
                $display("FAIL wrap_ready cyc=%0d got %b want %b", cyc, obs_ready, exp_ready);
            end
            checks++;
            if (din_valid && obs_ready) pushed++;
            cyc++;
        end
        din_valid = 1'b0; rdy = 4'h0;
        checks++;
        if (popped[0].size() != n) begin
            errors++;
            $display("FAIL wrap_budget got %0d words want %0d", popped[0].size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (popped[0][i] !== 32'hC000_0000 + DW'(i)) begin
                    errors++;
                    $display("FAIL wrap_order i=%0d got %h want %h", i, popped[0][i], 32'hC000_0000 + DW'(i));
                end
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_d;
        logic          held = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!held) begin
                sel       = 2'($urandom_range(0, 3));
                din       = $urandom;
                din_valid = 1'($urandom_range(0, 1));
            end
            rdy = 4'($urandom_range(0, 15));
            step();
            held = din_valid && !obs_ready;
            checks++;
            if (obs_ready !== exp_ready) begin
                errors++;
                $display("FAIL rand_ready c=%0d got %b want %b", c, obs_ready, exp_ready);
            end
            for (int k = 0; k < 4; k++) begin
                exp_d = (q[k].size() != 0) ? q[k][0] : '0;
                checks++;
                if (vld_a[k] !== (q[k].size() != 0) || dout_a[k] !== exp_d) begin
                    errors++;
                    $display("FAIL rand_port c=%0d k=%0d got %b/%h want %b/%h",
                             c, k, vld_a[k], dout_a[k], (q[k].size() != 0), exp_d);
                end
            end
        end
        din_valid = 1'b0; rdy = 4'hF;
        repeat (DEPTH + 1) step();
        rdy = 4'h0;
    endtask

    task automatic test_reset_mid();
        rdy = 4'h0; din_valid = 1'b1;
        sel = 2'd0; din = 32'hD000_0000; step();
        sel = 2'd3; din = 32'hD300_0000; step();
        din_valid = 1'b0; sel = 2'd0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) q[k].delete();
        checks++;
        if (vld_a !== 4'h0 || dout_a[0] !== '0 || dout_a[3] !== '0 || din_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_clear got valid=%b d0=%h d3=%h ready=%b want 0000/0/0/1",
                     vld_a, dout_a[0], dout_a[3], din_ready);
        end
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        sel = 2'd3; din = 32'hD3AB_CDEF; din_valid = 1'b1;
        step();
        checks++;
        if (vld_a !== 4'b1000 || dout_a[3] !== 32'hD3AB_CDEF) begin
            errors++;
            $display("FAIL midreset_push got valid=%b d3=%h want 1000/d3abcdef", vld_a, dout_a[3]);
        end
        din_valid = 1'b0; rdy = 4'b1000;
        step();
        checks++;
        if (vld_a !== 4'h0 || dout_a[3] !== '0) begin
            errors++;
            $display("FAIL midreset_sole got valid=%b d3=%h want 0000/0", vld_a, dout_a[3]);
        end
        rdy = 4'h0;
    endtask

    initial begin
        test_reset();
        test_routing();
        test_backpressure();
        test_full_pop();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
